// File: rtl/msg_sched_if.sv
// msg_sched block interface: message-word input handshake
// plus schedule word output with round index and framing.
interface msg_sched_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] w_out;
  logic        w_valid;
  logic [5:0]  t_out;
  logic        soc;
  logic        eoc;

  modport master (
    output in_data, in_valid,
    input  in_ready, w_out, w_valid, t_out, soc, eoc
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, w_out, w_valid, t_out, soc, eoc
  );
endinterface

// File: rtl/msg_sched.sv
// SHA-256 message schedule: loads 16 words, then streams
// W_0..W_{NROUNDS-1} one per cycle from a 16-word window.
module msg_sched #(
  parameter int NROUNDS = 64
) (
  input logic        clk,
  input logic        rst,
  msg_sched_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] TLAST = 6'(NROUNDS - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] w [16];
  logic [3:0]  lcnt;
  logic [5:0]  t;
  logic        xfer;
  logic        last_word;
  logic        last_round;
  logic        run;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(
    input logic [31:0] x
  );
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(
    input logic [31:0] x
  );
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'b0, x[31:10]};
  endfunction

  assign run        = (state == RUN);
  assign xfer       = (state == LOAD) && bus.in_valid;
  assign last_word  = xfer && (lcnt == 4'd15);
  assign last_round = run && (t == TLAST);
  assign w_new      = sig1(w[14]) + w[9]
                    + sig0(w[1]) + w[0];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // next-state: LOAD until 16th word, RUN for all rounds, one DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (last_word)  state_nx = RUN;
      RUN:     if (last_round) state_nx = DONE;
      DONE:    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // outputs: word/index only shown while streaming
  always_comb begin
    bus.in_ready = (state == LOAD);
    bus.w_valid  = run;
    bus.w_out    = '0;
    bus.t_out    = '0;
    bus.soc      = last_word;
    bus.eoc      = (state == DONE);
    if (run) begin
      bus.w_out = w[0];
      bus.t_out = t;
    end
  end

  // window shift on load or expansion; counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      lcnt <= '0;
      t    <= '0;
    end else begin
      if (xfer || run) begin
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= run ? w_new : bus.in_data;
      end
      // 4-bit count wraps to 0 on the 16th word
      if (xfer) lcnt <= lcnt + 4'd1;
      // t parks at the last round; cleared on entry to RUN
      if (last_word)
        t <= '0;
      else if (run && !last_round)
        t <= t + 6'd1;
    end
  end

endmodule
